// File: rtl/bomb_fuse.sv
// Bomb placement and fuse timer: snaps a dropped bomb to the grid, runs the fuse and
// issues a one-cycle blast, then waits for the blast unit's explode to rise and fall.
// Optional macro REMOTE_DETONATE_EN adds a remoteTrig input that detonates like chainHit.
//
// Handshake: blast is a one-cycle request carrying X/Y/radius; the blast unit acknowledges
// by raising explode and completes by dropping it. X/Y/radius are held stable until then.
module bomb_fuse #(
  parameter int FUSE_SECONDS = 3,
  parameter int GRID_LOG2    = 5,
  parameter int MAX_RADIUS   = 3,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        OneSecPulse,
  input  logic        startOfFrame,
  input  logic        placeBomb,
  input  logic [10:0] player_topLeftX,
  input  logic [10:0] player_topLeftY,
  input  logic        radiusUp,
  input  logic        chainHit,
  input  logic        explode,
`ifdef REMOTE_DETONATE_EN
  input  logic        remoteTrig,
`endif
  output logic [10:0] bomb_topLeftX,
  output logic [10:0] bomb_topLeftY,
  output logic [1:0]  blastRadius,
  output logic        blast,
  output logic        bombVisible,
  output logic [2:0]  fuseLeft,
  output logic [1:0]  state_dbg_o
);

  typedef enum logic [1:0] {
    s_idle    = 2'd0,
    s_armed   = 2'd1,
    s_wait_hi = 2'd2,
    s_wait_lo = 2'd3
  } state_t;

  localparam logic [11:0] HALF_CELL = 12'(1 << (GRID_LOG2 - 1));
  localparam logic [11:0] MAX_X     = 12'(SCREEN_W - 32);
  localparam logic [11:0] MAX_Y     = 12'(SCREEN_H - 32);

  state_t      state_q;
  logic [10:0] bomb_x_q, bomb_y_q;
  logic [1:0]  radius_q, pwr_q, pwr_d;
  logic        blast_q, visible_q;
  logic [2:0]  fuse_q, flash_q;

  logic [11:0] sum_x, sum_y, snap_x, snap_y;
  logic [10:0] place_x, place_y;
  logic        detonate;

  // Round to the nearest cell, then keep the whole cell on screen.
  always_comb begin
    sum_x   = {1'b0, player_topLeftX} + HALF_CELL;
    sum_y   = {1'b0, player_topLeftY} + HALF_CELL;
    snap_x  = (sum_x >> GRID_LOG2) << GRID_LOG2;
    snap_y  = (sum_y >> GRID_LOG2) << GRID_LOG2;
    place_x = (snap_x > MAX_X) ? MAX_X[10:0] : snap_x[10:0];
    place_y = (snap_y > MAX_Y) ? MAX_Y[10:0] : snap_y[10:0];
  end

  always_comb begin
    pwr_d = pwr_q;
    if (radiusUp && (pwr_q < 2'(MAX_RADIUS)))
      pwr_d = pwr_q + 2'd1;
  end

`ifdef REMOTE_DETONATE_EN
  assign detonate = (OneSecPulse && (fuse_q == 3'd1)) || chainHit || remoteTrig;
`else
  assign detonate = (OneSecPulse && (fuse_q == 3'd1)) || chainHit;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= s_idle;
      bomb_x_q  <= 11'(SCREEN_W);
      bomb_y_q  <= 11'(SCREEN_H);
      radius_q  <= 2'd1;
      pwr_q     <= 2'd1;
      blast_q   <= 1'b0;
      visible_q <= 1'b0;
      fuse_q    <= 3'd0;
      flash_q   <= 3'd0;
    end else begin
      pwr_q   <= pwr_d;
      blast_q <= 1'b0;
      case (state_q)
        s_idle: begin
          if (placeBomb) begin
            bomb_x_q  <= place_x;
            bomb_y_q  <= place_y;
            radius_q  <= pwr_q;
            fuse_q    <= 3'(FUSE_SECONDS);
            visible_q <= 1'b1;
            flash_q   <= 3'd0;
            state_q   <= s_armed;
          end
        end
        s_armed: begin
          if (detonate) begin
            blast_q   <= 1'b1;
            visible_q <= 1'b0;
            fuse_q    <= 3'd0;
            state_q   <= s_wait_hi;
          end else begin
            if (OneSecPulse)
              fuse_q <= fuse_q - 3'd1;
            // Last second: blink the sprite every 8 frames.
            if ((fuse_q == 3'd1) && startOfFrame) begin
              flash_q <= flash_q + 3'd1;
              if (flash_q == 3'd7)
                visible_q <= ~visible_q;
            end
          end
        end
        s_wait_hi: begin
          if (explode)
            state_q <= s_wait_lo;
        end
        s_wait_lo: begin
          if (!explode) begin
            bomb_x_q <= 11'(SCREEN_W);
            bomb_y_q <= 11'(SCREEN_H);
            state_q  <= s_idle;
          end
        end
        default: state_q <= s_idle;
      endcase
    end
  end

  assign bomb_topLeftX = bomb_x_q;
  assign bomb_topLeftY = bomb_y_q;
  assign blastRadius   = radius_q;
  assign blast         = blast_q;
  assign bombVisible   = visible_q;
  assign fuseLeft      = fuse_q;
  assign state_dbg_o   = state_q;

endmodule
